ipm_register_bank: RTL and testbench
====================================

// Module: ipm_register_bank
// PURPOSE
//   Parametrised MCU<->IP register bank; successor of the fixed 32-bit/8-bit bank.
//   Byte-addressed MCU port maps an N-byte IP data word, config, a self-clearing command reg and a status reg.
//   Generates one-cycle READ/WRITE/START strobes; tracks BUSY/DONE/OVERRUN from IP done; captures IP result.
//   Sits between the MCU bus adapter and one IP core.
// PARAMETERS
//   DATA_WIDTH_MCU  8   MCU bus width (bits)
//   DATA_WIDTH_IP   32  IP data width; must be an integer multiple of DATA_WIDTH_MCU
//   ADDR_WIDTH      4   MCU address width; 2**ADDR_WIDTH >= NB+4
//   CONF_WIDTH      5   config reg width; <= DATA_WIDTH_MCU
//   (local) NB = DATA_WIDTH_IP/DATA_WIDTH_MCU; A_CONF=NB, A_CTRL=NB+1, A_STAT=NB+2, A_MASK=NB+3
// PORTS
//   clk_n_Hz       in   1               single clock, rising edge
//   rst_async_low  in   1               asynchronous, active-low reset
//   dataMCUIn      in   DATA_WIDTH_MCU  MCU write data
//   dataMCUOut     out  DATA_WIDTH_MCU  MCU read data (combinational on address)
//   wr             in   1               MCU write strobe, sampled on clock edge
//   address        in   ADDR_WIDTH      MCU register address
//   dataInIPo      out  DATA_WIDTH_IP   concatenated write bytes, byte 0 = LSBs
//   configIPo      out  CONF_WIDTH      config register
//   readIPo        out  1               1-cycle strobe: IP presents result
//   writeIPo       out  1               1-cycle strobe: IP consumes dataInIPo
//   startIPo       out  1               1-cycle strobe: IP starts operation
//   dataOutIPi     in   DATA_WIDTH_IP   IP result word
//   doneIPi        in   1               IP done (level or pulse; rising edge used)
//   intMCUo        out  1               interrupt, only with IPM_REGISTER_INT_EN
// BEHAVIOUR
//   Reset: all regs 0; all strobes 0; dataInIPo=0, configIPo=0, status=0, intMCUo=0; done_prev=0.
//   Write map (wr=1): addr<NB -> byte[addr]; A_CONF -> conf<=din[CONF_WIDTH-1:0];
//     A_CTRL -> cmd bits {2:START,1:WRITE,0:READ}; A_STAT -> write-1-to-clear DONE(bit0), OVERRUN(bit2).
//   Read map: addr<NB -> result byte[addr]; A_CONF -> conf zero-ext; A_CTRL -> 0;
//     A_STAT -> {0..,OVERRUN,BUSY,DONE}; A_MASK -> mask (0 without macro); other -> 0.
//   Commands: ctrl write sampled at edge k -> matching strobe(s) high from edge k+1 to k+2 exactly;
//     command bits self-clear, no re-arm needed; several bits in one write -> strobes in same cycle.
//   Back-to-back ctrl writes at k, k+1 -> strobes in cycles k+1 and k+2 (no merge, no loss).
//   START accepted only if BUSY=0: sets BUSY at edge k+1, clears DONE. If BUSY=1: no startIPo, OVERRUN<=1.
//   doneIPi rising (doneIPi=1, done_prev=0) at edge m: DONE<=1, BUSY<=0, result<=dataOutIPi.
//   readIPo strobe cycle: result<=dataOutIPi at its closing edge (explicit re-read).
//   Simultaneous done-rise and W1C of DONE -> set wins. Done-rise and accepted START same edge -> START wins
//     (BUSY=1, DONE=0), result still captured.
//   doneIPi held high: no further edges; DONE not re-set after clear until doneIPi falls and rises.
//   Reset mid-operation: strobes drop immediately, BUSY/DONE cleared; no pending command survives.
//   Writes to read-only or unmapped addresses ignored.
// CONFIGURATION
//   Macro IPM_REGISTER_INT_EN:
//   defined: port intMCUo and reg A_MASK (bits 0,2 used) exist; intMCUo registered =
//     |(status & mask) over DONE,OVERRUN; asserts cycle after status bit sets, drops cycle after W1C.
//   undefined: no intMCUo port, A_MASK reads 0, writes ignored; otherwise identical.
// STRUCTURE
//   Package ipm_pkg: ctrl bit indices (CTRL_RD=0, CTRL_WR=1, CTRL_ST=2), status indices
//     (ST_DONE=0, ST_BUSY=1, ST_OVR=2), address-offset constants relative to NB.
//   Sub-module ipm_cmd_pulse: per-command one-shot register (set by ctrl write, self-clears); x3.
//   Byte registers via generate loop over NB; elaboration check of width/addr constraints.
// TESTING
//   1 Reset, read every address -> all 0; strobes 0; with macro intMCUo=0.
//   2 DATA_WIDTH_IP=32: write 0x11,0x22,0x33,0x44 to addr 0..3, ctrl=0x02 -> dataInIPo=0x44332211, one writeIPo cycle.
//   3 ctrl=0x04 -> startIPo 1 cycle, status=0x02; doneIPi pulse, dataOutIPi=0xCAFEF00D -> status=0x01, addr0..3 read 0x0D,0xF0,0xFE,0xCA.
//   4 ctrl=0x04 twice while BUSY -> one startIPo only, status=0x06; write 0x04 to A_STAT -> status=0x02.
//   5 done-rise same edge as W1C DONE -> status DONE=1; reset asserted during startIPo -> strobe drops, status=0.
//   6 macro on, mask=0x01: done-rise -> intMCUo=1 next cycle; W1C DONE -> intMCUo=0; repeat with DATA_WIDTH_IP=64, NB=8.

Source files
------------

// File: rtl/ipm_pkg.sv
// Shared constants for the MCU<->IP register bank: control/status bit positions
// and register offsets relative to the number of data bytes.
package ipm_pkg;

  localparam int CTRL_RD = 0;
  localparam int CTRL_WR = 1;
  localparam int CTRL_ST = 2;
  localparam int NUM_CMDS = 3;

  localparam int ST_DONE = 0;
  localparam int ST_BUSY = 1;
  localparam int ST_OVR  = 2;

  localparam int OFS_CONF = 0;
  localparam int OFS_CTRL = 1;
  localparam int OFS_STAT = 2;
  localparam int OFS_MASK = 3;

  // Field order matches the ST_* bit positions (done is the LSB).
  typedef struct packed {
    logic ovr;
    logic busy;
    logic done;
  } status_t;

endpackage

// File: rtl/ipm_cmd_pulse.sv
// One-shot command register: a control write arms it for one cycle, and the
// strobe fires on the following cycle if the gate allows it.
module ipm_cmd_pulse (
  input  logic clk,
  input  logic rst_n,
  input  logic set,
  input  logic gate,
  output logic pending,
  output logic pulse
);

  logic pending_reg;
  logic pulse_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg <= 1'b0;
      pulse_reg   <= 1'b0;
    end else begin
      pending_reg <= set;
      pulse_reg   <= pending_reg & gate;
    end
  end

  assign pending = pending_reg;
  assign pulse   = pulse_reg;

endmodule

// File: rtl/ipm_register_bank.sv
// Parametrised MCU<->IP register bank with command strobes and BUSY/DONE/OVERRUN tracking.
// Optional interrupt output and mask register enabled by IPM_REGISTER_INT_EN.
module ipm_register_bank
  import ipm_pkg::*;
#(
  parameter int DATA_WIDTH_MCU = 8,
  parameter int DATA_WIDTH_IP  = 32,
  parameter int ADDR_WIDTH     = 4,
  parameter int CONF_WIDTH     = 5
) (
  input  logic                      clk_n_Hz,
  input  logic                      rst_async_low,
  input  logic [DATA_WIDTH_MCU-1:0] dataMCUIn,
  output logic [DATA_WIDTH_MCU-1:0] dataMCUOut,
  input  logic                      wr,
  input  logic [ADDR_WIDTH-1:0]     address,
  output logic [DATA_WIDTH_IP-1:0]  dataInIPo,
  output logic [CONF_WIDTH-1:0]     configIPo,
  output logic                      readIPo,
  output logic                      writeIPo,
  output logic                      startIPo,
  input  logic [DATA_WIDTH_IP-1:0]  dataOutIPi,
  input  logic                      doneIPi
`ifdef IPM_REGISTER_INT_EN
  , output logic                    intMCUo
`endif
);

  localparam int NB = DATA_WIDTH_IP / DATA_WIDTH_MCU;
  localparam logic [ADDR_WIDTH-1:0] A_CONF = ADDR_WIDTH'(NB + OFS_CONF);
  localparam logic [ADDR_WIDTH-1:0] A_CTRL = ADDR_WIDTH'(NB + OFS_CTRL);
  localparam logic [ADDR_WIDTH-1:0] A_STAT = ADDR_WIDTH'(NB + OFS_STAT);
  localparam logic [ADDR_WIDTH-1:0] A_MASK = ADDR_WIDTH'(NB + OFS_MASK);

  if ((DATA_WIDTH_IP % DATA_WIDTH_MCU) != 0 || (2 ** ADDR_WIDTH) < NB + 4 ||
      CONF_WIDTH < 1 || CONF_WIDTH > DATA_WIDTH_MCU || DATA_WIDTH_MCU < 3) begin : g_param_check
    $error("ipm_register_bank: illegal width/address parameter combination");
  end

  logic [DATA_WIDTH_MCU-1:0] byte_reg [NB];
  logic [DATA_WIDTH_IP-1:0]  result_reg;
  logic [CONF_WIDTH-1:0]     conf_reg;
  logic                      done_prev_reg;
  status_t                   status_reg;
  status_t                   status_next;
  logic [DATA_WIDTH_MCU-1:0] read_data;

  logic [NUM_CMDS-1:0] ctrl_set;
  logic [NUM_CMDS-1:0] cmd_gate;
  logic [NUM_CMDS-1:0] cmd_pending;
  logic [NUM_CMDS-1:0] cmd_pulse;
  logic                pending_unused;

  logic stat_wr;
  logic done_rise;
  logic start_accept;
  logic start_overrun;

  assign stat_wr       = wr && (address == A_STAT);
  assign ctrl_set      = (wr && (address == A_CTRL)) ? dataMCUIn[NUM_CMDS-1:0] : '0;
  assign done_rise     = doneIPi & ~done_prev_reg;
  assign start_accept  = cmd_pending[CTRL_ST] & ~status_reg.busy;
  assign start_overrun = cmd_pending[CTRL_ST] & status_reg.busy;
  assign pending_unused = cmd_pending[CTRL_RD] ^ cmd_pending[CTRL_WR];

  always_comb begin
    cmd_gate          = '1;
    cmd_gate[CTRL_ST] = ~status_reg.busy;
  end

  for (genvar gi = 0; gi < NUM_CMDS; gi++) begin : g_cmd
    ipm_cmd_pulse u_cmd (
      .clk     (clk_n_Hz),
      .rst_n   (rst_async_low),
      .set     (ctrl_set[gi]),
      .gate    (cmd_gate[gi]),
      .pending (cmd_pending[gi]),
      .pulse   (cmd_pulse[gi])
    );
  end

  for (genvar gi = 0; gi < NB; gi++) begin : g_byte
    always_ff @(posedge clk_n_Hz or negedge rst_async_low) begin
      if (!rst_async_low)
        byte_reg[gi] <= '0;
      else if (wr && (address == ADDR_WIDTH'(gi)))
        byte_reg[gi] <= dataMCUIn;
    end
    assign dataInIPo[gi*DATA_WIDTH_MCU +: DATA_WIDTH_MCU] = byte_reg[gi];
  end

  // Later assignments win: accepted START beats done-rise, which beats W1C.
  always_comb begin
    status_next = status_reg;
    if (stat_wr && dataMCUIn[ST_DONE]) status_next.done = 1'b0;
    if (stat_wr && dataMCUIn[ST_OVR])  status_next.ovr  = 1'b0;
    if (done_rise) begin
      status_next.done = 1'b1;
      status_next.busy = 1'b0;
    end
    if (start_overrun) status_next.ovr = 1'b1;
    if (start_accept) begin
      status_next.busy = 1'b1;
      status_next.done = 1'b0;
    end
  end

  always_ff @(posedge clk_n_Hz or negedge rst_async_low) begin
    if (!rst_async_low) begin
      status_reg    <= '0;
      result_reg    <= '0;
      conf_reg      <= '0;
      done_prev_reg <= 1'b0;
    end else begin
      status_reg    <= status_next;
      done_prev_reg <= doneIPi;
      if (done_rise || cmd_pulse[CTRL_RD]) result_reg <= dataOutIPi;
      if (wr && (address == A_CONF)) conf_reg <= dataMCUIn[CONF_WIDTH-1:0];
    end
  end

`ifdef IPM_REGISTER_INT_EN
  status_t mask_reg;
  logic    int_reg;

  always_ff @(posedge clk_n_Hz or negedge rst_async_low) begin
    if (!rst_async_low) begin
      mask_reg <= '0;
      int_reg  <= 1'b0;
    end else begin
      if (wr && (address == A_MASK)) begin
        mask_reg.done <= dataMCUIn[ST_DONE];
        mask_reg.busy <= 1'b0;
        mask_reg.ovr  <= dataMCUIn[ST_OVR];
      end
      int_reg <= |(status_reg & mask_reg);
    end
  end

  assign intMCUo = int_reg;
`endif

  always_comb begin
    read_data = '0;
    for (int i = 0; i < NB; i++)
      if (address == ADDR_WIDTH'(i)) read_data = result_reg[i*DATA_WIDTH_MCU +: DATA_WIDTH_MCU];
    if (address == A_CONF) read_data = DATA_WIDTH_MCU'(conf_reg);
    if (address == A_STAT) read_data = DATA_WIDTH_MCU'(status_reg);
`ifdef IPM_REGISTER_INT_EN
    if (address == A_MASK) read_data = DATA_WIDTH_MCU'(mask_reg);
`endif
  end

  assign dataMCUOut = read_data;
  assign configIPo  = conf_reg;
  assign readIPo    = cmd_pulse[CTRL_RD];
  assign writeIPo   = cmd_pulse[CTRL_WR];
  assign startIPo   = cmd_pulse[CTRL_ST];

endmodule

// File: tb/tb_ipm_register_bank.sv
// Randomised self-checking bench for ipm_register_bank (32-bit IP word, NB=4)
// against a transaction-level register model; covers IPM_REGISTER_INT_EN when defined.
module tb_ipm_register_bank;

  localparam int MW = 8;
  localparam int IW = 32;
  localparam int AW = 4;
  localparam int CW = 5;
  localparam int NB = IW / MW;
  localparam logic [AW-1:0] A_CONF = AW'(NB);
  localparam logic [AW-1:0] A_CTRL = AW'(NB + 1);
  localparam logic [AW-1:0] A_STAT = AW'(NB + 2);
  localparam logic [AW-1:0] A_MASK = AW'(NB + 3);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [MW-1:0] din = '0;
  logic [MW-1:0] dout;
  logic          wr = 1'b0;
  logic [AW-1:0] address = '0;
  logic [IW-1:0] data_in_ip;
  logic [CW-1:0] conf_ip;
  logic          rd_s, wr_s, st_s;
  logic [IW-1:0] dout_ip = '0;
  logic          done_ip = 1'b0;
  logic          int_o;

  ipm_register_bank #(
    .DATA_WIDTH_MCU(MW), .DATA_WIDTH_IP(IW), .ADDR_WIDTH(AW), .CONF_WIDTH(CW)
  ) dut (
`ifdef IPM_REGISTER_INT_EN
    .intMCUo       (int_o),
`endif
    .clk_n_Hz      (clk),
    .rst_async_low (rst_n),
    .dataMCUIn     (din),
    .dataMCUOut    (dout),
    .wr            (wr),
    .address       (address),
    .dataInIPo     (data_in_ip),
    .configIPo     (conf_ip),
    .readIPo       (rd_s),
    .writeIPo      (wr_s),
    .startIPo      (st_s),
    .dataOutIPi    (dout_ip),
    .doneIPi       (done_ip)
  );

`ifndef IPM_REGISTER_INT_EN
  assign int_o = 1'b0;
`endif

  always #5 clk = ~clk;

  // Behavioural register model
  logic [IW-1:0] m_bytes, m_result;
  logic [CW-1:0] m_conf;
  logic          m_done, m_busy, m_ovr;
  logic [1:0]    m_mask;  // {ovr, done}

  int n_checks = 0;
  int n_errors = 0;
  int n_rd = 0, n_wr = 0, n_st = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      n_rd <= n_rd + int'(rd_s);
      n_wr <= n_wr + int'(wr_s);
      n_st <= n_st + int'(st_s);
    end
  end

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic model_reset();
    m_bytes = '0; m_result = '0; m_conf = '0;
    m_done = 0; m_busy = 0; m_ovr = 0; m_mask = '0;
  endtask

  function automatic logic [MW-1:0] exp_read(input logic [AW-1:0] a);
    logic [IW-1:0] t;
    if (int'(a) < NB) begin
      t = m_result >> (MW * int'(a));
      return t[MW-1:0];
    end
    if (a == A_CONF) return MW'(m_conf);
    if (a == A_STAT) return {5'b0, m_ovr, m_busy, m_done};
`ifdef IPM_REGISTER_INT_EN
    if (a == A_MASK) return {5'b0, m_mask[1], 1'b0, m_mask[0]};
`endif
    return '0;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [AW-1:0] a, input logic [MW-1:0] d);
    @(negedge clk);
    address = a; din = d; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic bus_read_check(input string tag, input logic [AW-1:0] a);
    @(negedge clk);
    address = a;
    #1 check_value($sformatf("%s[%0d]", tag, a), dout, exp_read(a));
  endtask

  task automatic do_byte(input logic [AW-1:0] a, input logic [MW-1:0] d);
    bus_write(a, d);
    m_bytes[MW*int'(a) +: MW] = d;
  endtask

  task automatic do_ctrl(input logic [MW-1:0] d);
    int r0, w0, s0;
    logic exp_st;
    r0 = n_rd; w0 = n_wr; s0 = n_st;
    exp_st = d[2] && !m_busy;
    bus_write(A_CTRL, d);
    idle(3);
    if (d[2]) begin
      if (m_busy) m_ovr = 1'b1;
      else begin m_busy = 1'b1; m_done = 1'b0; end
    end
    if (d[0]) m_result = dout_ip;
    check_value("rd_strobes", n_rd - r0, d[0]);
    check_value("wr_strobes", n_wr - w0, d[1]);
    check_value("st_strobes", n_st - s0, exp_st);
  endtask

  task automatic do_stat(input logic [MW-1:0] d);
    bus_write(A_STAT, d);
    if (d[0]) m_done = 1'b0;
    if (d[2]) m_ovr = 1'b0;
  endtask

  task automatic do_done(input logic [IW-1:0] v);
    @(negedge clk);
    dout_ip = v; done_ip = 1'b1;
    @(negedge clk);
    done_ip = 1'b0;
    m_done = 1'b1; m_busy = 1'b0; m_result = v;
    idle(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] a;
    logic [MW-1:0] d;
    int s0, w0;
    model_reset();

    // Reset: every address reads 0, strobes idle
    idle(2);
    for (int i = 0; i < 16; i++) begin
      address = AW'(i);
      #1 check_value($sformatf("reset_rd[%0d]", i), dout, 8'h00);
    end
    check_value("reset_strobes", {rd_s, wr_s, st_s}, 3'b000);
    check_value("reset_int", int_o, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    idle(1);

    // Write data bytes then a WRITE command; check exact strobe timing
    do_byte(0, 8'h11); do_byte(1, 8'h22); do_byte(2, 8'h33); do_byte(3, 8'h44);
    check_value("data_in_ip", data_in_ip, 32'h4433_2211);
    w0 = n_wr;
    bus_write(A_CTRL, 8'h02);
    check_value("wr_strobe_k", wr_s, 1'b0);
    @(negedge clk) check_value("wr_strobe_k1", wr_s, 1'b1);
    @(negedge clk) check_value("wr_strobe_k2", wr_s, 1'b0);
    idle(1);
    check_value("wr_strobe_count", n_wr - w0, 1);

    // START, then done with result capture
    do_ctrl(8'h04);
    bus_read_check("busy_stat", A_STAT);
    check_value("busy_const", dout, 8'h02);
    do_done(32'hCAFE_F00D);
    bus_read_check("done_stat", A_STAT);
    for (int i = 0; i < NB; i++) bus_read_check("result", AW'(i));

    // Back-to-back STARTs: second one overruns
    s0 = n_st;
    bus_write(A_CTRL, 8'h04);
    bus_write(A_CTRL, 8'h04);
    idle(3);
    m_busy = 1'b1; m_done = 1'b0; m_ovr = 1'b1;
    check_value("b2b_start_count", n_st - s0, 1);
    bus_read_check("ovr_stat", A_STAT);
    check_value("ovr_const", dout, 8'h06);
    do_stat(8'h04);
    bus_read_check("ovr_w1c", A_STAT);
    do_done(32'h1234_5678);

    // Back-to-back WRITE commands: two separate strobes
    w0 = n_wr;
    bus_write(A_CTRL, 8'h02);
    bus_write(A_CTRL, 8'h02);
    idle(3);
    check_value("b2b_wr_count", n_wr - w0, 2);

    // Done-rise coincides with W1C of DONE: set wins
    @(negedge clk);
    address = A_STAT; din = 8'h01; wr = 1'b1; done_ip = 1'b1; dout_ip = 32'hA5A5_0001;
    @(negedge clk);
    wr = 1'b0; done_ip = 1'b0;
    m_done = 1'b1; m_busy = 1'b0; m_result = 32'hA5A5_0001;
    bus_read_check("set_wins", A_STAT);
    bus_read_check("set_wins_res", 0);

    // Done held high: W1C sticks until a fresh rising edge
    @(negedge clk) begin done_ip = 1'b1; dout_ip = 32'h0BAD_0002; end
    idle(2);
    m_done = 1'b1; m_result = 32'h0BAD_0002;
    do_stat(8'h01);
    idle(3);
    bus_read_check("held_done", A_STAT);
    @(negedge clk) done_ip = 1'b0;
    idle(1);

    // Accepted START and done-rise on the same edge: START wins, result captured
    bus_write(A_CTRL, 8'h04);
    done_ip = 1'b1; dout_ip = 32'h7700_0003;
    @(negedge clk) done_ip = 1'b0;
    idle(2);
    m_busy = 1'b1; m_done = 1'b0; m_result = 32'h7700_0003;
    bus_read_check("start_wins", A_STAT);
    bus_read_check("start_wins_res", 0);
    do_done(32'h0000_0004);

    // Reset during the start strobe
    bus_write(A_CTRL, 8'h04);
    @(negedge clk) check_value("st_before_rst", st_s, 1'b1);
    rst_n = 1'b0;
    #1 check_value("st_after_rst", st_s, 1'b0);
    address = A_STAT;
    #1 check_value("stat_after_rst", dout, 8'h00);
    check_value("data_after_rst", data_in_ip, 32'h0);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    idle(2);
    bus_read_check("stat_post_rst", A_STAT);

`ifdef IPM_REGISTER_INT_EN
    // Interrupt on DONE with mask bit 0
    bus_write(A_MASK, 8'h01);
    m_mask = 2'b01;
    bus_read_check("mask_rd", A_MASK);
    @(negedge clk) begin dout_ip = 32'h0000_00AA; done_ip = 1'b1; end
    @(negedge clk) begin
      done_ip = 1'b0;
      check_value("int_same_cycle", int_o, 1'b0);
    end
    @(negedge clk) check_value("int_next_cycle", int_o, 1'b1);
    m_done = 1'b1; m_result = 32'h0000_00AA;
    bus_write(A_STAT, 8'h01);
    m_done = 1'b0;
    check_value("int_hold", int_o, 1'b1);
    @(negedge clk) check_value("int_drop", int_o, 1'b0);
`endif

    // Randomised traffic against the model
    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 6))
        0: do_byte(AW'($urandom_range(0, NB - 1)), MW'($urandom));
        1: begin
          d = MW'($urandom);
          bus_write(A_CONF, d);
          m_conf = d[CW-1:0];
        end
        2: begin
          dout_ip = $urandom;
          do_ctrl(MW'($urandom_range(0, 7)));
        end
        3: do_stat(MW'($urandom));
        4: do_done($urandom);
        5: begin
          bus_read_check("rnd_rd", AW'($urandom_range(0, 15)));
          check_value("rnd_data_in", data_in_ip, m_bytes);
          check_value("rnd_conf", conf_ip, m_conf);
          check_value("rnd_int", int_o, |({m_ovr, m_done} & m_mask));
        end
        default: begin
          a = AW'($urandom_range(NB + 3, 15));
          d = MW'($urandom);
          bus_write(a, d);
`ifdef IPM_REGISTER_INT_EN
          if (a == A_MASK) m_mask = {d[2], d[0]};
`endif
        end
      endcase
    end

    idle(2);
    for (int i = 0; i < 16; i++) bus_read_check("final_rd", AW'(i));
    check_value("final_data_in", data_in_ip, m_bytes);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
